pool_flat_engine: RTL

//  Parametrised max-pool + flatten engine for the CONV datapath (layer 1/2).
//  - Reads NCH layer-0 channel maps (IMGW x IMGW) through the shared crd/cwr/csel memory port.
//  - Max-pools each map with a POOL x POOL window at stride POOL and writes the layer-1 maps.
//  - Optionally writes a channel-interleaved flattened layer-2 vector.
//  - Generalises the fixed 2-channel, 2x2, 64x64 pooling stage: width, channel count, window and signedness are now parameters.

---
 rtl/pool_flat_engine.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pool_flat_engine.sv
`default_nettype none
// ==========================================================================
// pool_flat_engine : POOLxPOOL max-pool of NCH layer-0 maps into layer-1
//                    maps, with an optional channel-interleaved flatten.
// Rev 1.0
// ==========================================================================
module pool_flat_engine #(
  parameter int DATAW  = 20,
  parameter int IMGW   = 64,
  parameter int POOL   = 2,
  parameter int NCH    = 2,
  parameter int SIGNED = 0,
  parameter int ADDRW  = 12,
  parameter int CSELW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             flat_en,
  output logic             busy,
  output logic             done,
  output logic             crd,
  output logic [ADDRW-1:0] caddr_rd,
  input  logic [DATAW-1:0] cdata_rd,
  output logic             cwr,
  output logic [ADDRW-1:0] caddr_wr,
  output logic [DATAW-1:0] cdata_wr,
  output logic [CSELW-1:0] csel
);

  localparam int c_OW   = IMGW / POOL;
  localparam int c_NWIN = POOL * POOL;
  localparam int c_KW   = (c_NWIN > 1) ? $clog2(c_NWIN) : 1;
  localparam int c_OWW  = (c_OW > 1) ? $clog2(c_OW) : 1;
  localparam int c_CW   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_RD   = 3'd1;
  localparam logic [2:0] c_S_LAST = 3'd2;
  localparam logic [2:0] c_S_WL1  = 3'd3;
  localparam logic [2:0] c_S_WFL  = 3'd4;
  localparam logic [2:0] c_S_DONE = 3'd5;

  logic [2:0]       r_state, w_state_nx;
  logic [c_KW-1:0]  r_k, w_k_nx;
  logic [c_OWW-1:0] r_ox, r_oy, w_ox_nx, w_oy_nx;
  logic [c_CW-1:0]  r_c, w_c_nx;
  logic             r_flat, w_flat_nx;
  logic [DATAW-1:0] r_max, w_max_nx;
  logic             w_gt, w_sample, w_first, w_last_item, w_adv;

  logic             r_busy, r_done, r_crd, r_cwr;
  logic [ADDRW-1:0] r_caddr_rd, r_caddr_wr;
  logic [DATAW-1:0] r_cdata_wr;
  logic [CSELW-1:0] r_csel;
  logic             w_busy_nx, w_done_nx, w_crd_nx, w_cwr_nx;
  logic [ADDRW-1:0] w_caddr_rd_nx, w_caddr_wr_nx;
  logic [DATAW-1:0] w_cdata_wr_nx;
  logic [CSELW-1:0] w_csel_nx;

  generate
    if (SIGNED != 0) begin : g_signed_cmp
      assign w_gt = $signed(cdata_rd) > $signed(r_max);
    end else begin : g_unsigned_cmp
      assign w_gt = cdata_rd > r_max;
    end
  endgenerate

  // Read k-1 lands while in RD at k>=1; the final read lands in LAST.
  assign w_sample    = ((r_state == c_S_RD) && (r_k != '0)) || (r_state == c_S_LAST);
  assign w_first     = ((r_state == c_S_RD) && (r_k == c_KW'(1))) ||
                       ((r_state == c_S_LAST) && (c_NWIN == 1));
  assign w_max_nx    = (w_sample && (w_first || w_gt)) ? cdata_rd : r_max;
  assign w_last_item = (r_c == c_CW'(NCH - 1)) && (r_ox == c_OWW'(c_OW - 1)) &&
                       (r_oy == c_OWW'(c_OW - 1));

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_S_IDLE;
      r_k        <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_c        <= '0;
      r_flat     <= 1'b0;
      r_max      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_csel     <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_k        <= w_k_nx;
      r_ox       <= w_ox_nx;
      r_oy       <= w_oy_nx;
      r_c        <= w_c_nx;
      r_flat     <= w_flat_nx;
      r_max      <= w_max_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_crd      <= w_crd_nx;
      r_cwr      <= w_cwr_nx;
      r_caddr_rd <= w_caddr_rd_nx;
      r_caddr_wr <= w_caddr_wr_nx;
      r_cdata_wr <= w_cdata_wr_nx;
      r_csel     <= w_csel_nx;
    end
  end

  // Next state and loop counters: channel innermost, then ox, then oy
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_ox_nx    = r_ox;
    w_oy_nx    = r_oy;
    w_c_nx     = r_c;
    w_flat_nx  = r_flat;
    w_adv      = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (ready) begin
          w_state_nx = c_S_RD;
          w_k_nx     = '0;
          w_ox_nx    = '0;
          w_oy_nx    = '0;
          w_c_nx     = '0;
          w_flat_nx  = flat_en;
        end
      end
      c_S_RD: begin
        if (r_k == c_KW'(c_NWIN - 1)) begin
          w_k_nx     = '0;
          w_state_nx = c_S_LAST;
        end else begin
          w_k_nx = r_k + c_KW'(1);
        end
      end
      c_S_LAST: w_state_nx = c_S_WL1;
      c_S_WL1: begin
        if (r_flat) w_state_nx = c_S_WFL;
        else        w_adv      = 1'b1;
      end
      c_S_WFL:  w_adv      = 1'b1;
      c_S_DONE: w_state_nx = c_S_IDLE;
      default:  w_state_nx = c_S_IDLE;
    endcase

    if (w_adv) begin
      if (w_last_item) begin
        w_state_nx = c_S_DONE;
        w_c_nx     = '0;
        w_ox_nx    = '0;
        w_oy_nx    = '0;
      end else begin
        w_state_nx = c_S_RD;
        if (r_c == c_CW'(NCH - 1)) begin
          w_c_nx = '0;
          if (r_ox == c_OWW'(c_OW - 1)) begin
            w_ox_nx = '0;
            w_oy_nx = r_oy + c_OWW'(1);
          end else begin
            w_ox_nx = r_ox + c_OWW'(1);
          end
        end else begin
          w_c_nx = r_c + c_CW'(1);
        end
      end
    end
  end

  // Output values for the upcoming state, so every port is a flop
  always_comb begin
    w_busy_nx     = (w_state_nx == c_S_RD) || (w_state_nx == c_S_LAST) ||
                    (w_state_nx == c_S_WL1) || (w_state_nx == c_S_WFL);
    w_done_nx     = (w_state_nx == c_S_DONE);
    w_crd_nx      = (w_state_nx == c_S_RD);
    w_cwr_nx      = (w_state_nx == c_S_WL1) || (w_state_nx == c_S_WFL);
    w_caddr_rd_nx = r_caddr_rd;
    w_caddr_wr_nx = r_caddr_wr;
    w_cdata_wr_nx = r_cdata_wr;
    w_csel_nx     = '0;
    case (w_state_nx)
      c_S_RD: begin
        w_csel_nx     = CSELW'(1) + CSELW'(w_c_nx);
        w_caddr_rd_nx = ADDRW'((int'(w_oy_nx) * POOL + int'(w_k_nx) / POOL) * IMGW +
                               int'(w_ox_nx) * POOL + int'(w_k_nx) % POOL);
      end
      c_S_LAST: w_csel_nx = CSELW'(1) + CSELW'(w_c_nx);
      c_S_WL1: begin
        w_csel_nx     = CSELW'(NCH + 1) + CSELW'(w_c_nx);
        w_caddr_wr_nx = ADDRW'(int'(w_oy_nx) * c_OW + int'(w_ox_nx));
        w_cdata_wr_nx = w_max_nx;
      end
      c_S_WFL: begin
        w_csel_nx     = CSELW'(2 * NCH + 1);
        w_caddr_wr_nx = ADDRW'((int'(w_oy_nx) * c_OW + int'(w_ox_nx)) * NCH + int'(w_c_nx));
        w_cdata_wr_nx = w_max_nx;
      end
      default: w_csel_nx = '0;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign cwr      = r_cwr;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
  assign csel     = r_csel;

endmodule
`default_nettype wire
